cpu_controller: RTL and testbench

//   Instruction-cycle sequencer for the mini CPU; it is the control-side counterpart of the ALU.
//   It steps a fixed 8-state fetch/execute cycle, decodes the 3-bit opcode from the instruction

---
 rtl/cpu_controller.sv | 134 +++++++++++++
 tb/tb_cpu_controller.sv | 125 ++++++++++++
 2 files changed

// File: rtl/cpu_controller.sv
// Fetch/execute sequencer for the mini CPU: walks an 8-state instruction cycle,
// decodes the latched opcode and drives registered, glitch-free control strobes.
module cpu_controller (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [2:0] opcode,
   input  logic       zero,
   output logic       inc_pc,
   output logic       load_pc,
   output logic       load_ir,
   output logic       load_acc,
   output logic       rd,
   output logic       wr,
   output logic       datactl_ena,
   output logic       alu_clk,
   output logic       halt
);

   localparam logic [2:0] HLT  = 3'd0;
   localparam logic [2:0] SKZ  = 3'd1;
   localparam logic [2:0] ADD  = 3'd2;
   localparam logic [2:0] ANDD = 3'd3;
   localparam logic [2:0] XORR = 3'd4;
   localparam logic [2:0] LDA  = 3'd5;
   localparam logic [2:0] STO  = 3'd6;
   localparam logic [2:0] JMP  = 3'd7;

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      S0     = 4'd1,
      S1     = 4'd2,
      S2     = 4'd3,
      S3     = 4'd4,
      S4     = 4'd5,
      S5     = 4'd6,
      S6     = 4'd7,
      S7     = 4'd8,
      HALTED = 4'd9
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] opc_q, opc_d;
   logic       zero_q, zero_d;
   logic [8:0] out_q, out_d;
   logic       alu_grp_s;

   always_comb begin
      state_d = state_q;
      opc_d   = opc_q;
      zero_d  = zero_q;
      case (state_q)
         IDLE:    begin
            if (ena) state_d = S0;
            else     state_d = IDLE;
         end
         S0:      state_d = S1;
         S1:      state_d = S2;
         S2:      begin
            state_d = S3;
            opc_d   = opcode;
         end
         S3:      begin
            if (opc_q == HLT) state_d = HALTED;
            else              state_d = S4;
         end
         S4:      begin
            state_d = S5;
            zero_d  = zero;
         end
         S5:      state_d = S6;
         S6:      state_d = S7;
         S7:      begin
            if (ena) state_d = S0;
            else     state_d = IDLE;
         end
         HALTED:  state_d = HALTED;
         default: state_d = IDLE;
      endcase
   end

   assign alu_grp_s = (opc_d == ADD) || (opc_d == ANDD) || (opc_d == XORR) || (opc_d == LDA);

   // Outputs are decoded from the state being entered so each register holds for the whole state.
   // Bit order: {inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, alu_clk, halt}
   always_comb begin
      out_d = 9'b0;
      case (state_d)
         S0:     out_d = 9'b0_0_1_0_1_0_0_0_0;
         S1:     out_d = 9'b1_0_1_0_1_0_0_0_0;
         S3:     out_d = 9'b1_0_0_0_0_0_0_0_0;
         S4:     begin
            if (alu_grp_s)           out_d = 9'b0_0_0_0_1_0_0_0_0;
            else if (opc_d == STO)   out_d = 9'b0_0_0_0_0_0_1_0_0;
            else if (opc_d == JMP)   out_d = 9'b0_1_0_0_0_0_0_0_0;
            else                     out_d = 9'b0;
         end
         S5:     begin
            if (alu_grp_s)                     out_d = 9'b0_0_0_0_1_0_0_1_0;
            else if (opc_d == STO)             out_d = 9'b0_0_0_0_0_1_1_0_0;
            else if ((opc_d == SKZ) && zero_d) out_d = 9'b1_0_0_0_0_0_0_0_0;
            else                               out_d = 9'b0;
         end
         S6:     begin
            if (alu_grp_s)           out_d = 9'b0_0_0_1_0_0_0_0_0;
            else if (opc_d == STO)   out_d = 9'b0_0_0_0_0_0_1_0_0;
            else                     out_d = 9'b0;
         end
         S7:     begin
            if ((opc_d == SKZ) && zero_d) out_d = 9'b1_0_0_0_0_0_0_0_0;
            else                          out_d = 9'b0;
         end
         HALTED: out_d = 9'b0_0_0_0_0_0_0_0_1;
         default: out_d = 9'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         opc_q   <= 3'd0;
         zero_q  <= 1'b0;
         out_q   <= 9'b0;
      end else begin
         state_q <= state_d;
         opc_q   <= opc_d;
         zero_q  <= zero_d;
         out_q   <= out_d;
      end
   end

   assign {inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, alu_clk, halt} = out_q;

endmodule

// File: tb/tb_cpu_controller.sv
// Randomized bench for cpu_controller against a step-counting instruction-cycle model.
module tb_cpu_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic       ena;
   logic [2:0] opcode;
   logic       zero;
   logic       inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, alu_clk, halt;

   int passed = 0;
   int total  = 0;

   // model: mode 0 = idle, 1 = running instruction at step m_step (0..7), 2 = halted
   int       m_mode;
   int       m_step;
   int       m_op;
   bit       m_z;
   int       halted_cycles;

   cpu_controller dut (
      .clk(clk), .rst(rst), .ena(ena), .opcode(opcode), .zero(zero),
      .inc_pc(inc_pc), .load_pc(load_pc), .load_ir(load_ir), .load_acc(load_acc),
      .rd(rd), .wr(wr), .datactl_ena(datactl_ena), .alu_clk(alu_clk), .halt(halt)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] outs();
      return {inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, alu_clk, halt};
   endfunction

   task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s got=%b exp=%b (mode=%0d step=%0d op=%0d)", tag, got, exp, m_mode, m_step, m_op);
   endtask

   function automatic logic [8:0] expected();
      bit alu, sto, jmp, skz;
      bit e_inc, e_lpc, e_lir, e_lacc, e_rd, e_wr, e_dctl, e_aclk;
      if (m_mode == 2) return 9'b0_0_0_0_0_0_0_0_1;
      if (m_mode == 0) return 9'b0;
      alu = (m_op >= 2) && (m_op <= 5);
      sto = (m_op == 6);
      jmp = (m_op == 7);
      skz = (m_op == 1);
      e_rd   = (m_step <= 1) || (alu && (m_step == 4 || m_step == 5));
      e_lir  = (m_step <= 1);
      e_inc  = (m_step == 1) || (m_step == 3) || (skz && m_z && (m_step == 5 || m_step == 7));
      e_aclk = alu && (m_step == 5);
      e_lacc = alu && (m_step == 6);
      e_dctl = sto && (m_step >= 4) && (m_step <= 6);
      e_wr   = sto && (m_step == 5);
      e_lpc  = jmp && (m_step == 4);
      return {e_inc, e_lpc, e_lir, e_lacc, e_rd, e_wr, e_dctl, e_aclk, 1'b0};
   endfunction

   task automatic model_reset();
      m_mode = 0; m_step = 0; m_op = 0; m_z = 1'b0; halted_cycles = 0;
   endtask

   // Advance the model by one clock using the inputs present at the edge.
   task automatic model_edge();
      if (m_mode == 2) begin
         halted_cycles++;
      end else if (m_mode == 0) begin
         if (ena) begin m_mode = 1; m_step = 0; end
      end else begin
         if (m_step == 2) m_op = int'(opcode);
         if (m_step == 4) m_z = zero;
         if (m_step == 3 && m_op == 0) m_mode = 2;
         else if (m_step == 7) begin
            if (ena) m_step = 0;
            else     m_mode = 0;
         end else m_step++;
      end
   endtask

   task automatic async_reset();
      #3;
      rst = 1'b1;
      #1;
      check_eq("async_rst", outs(), 9'b0);
      model_reset();
      #1;
      rst = 1'b0;
   endtask

   initial begin
      logic [2:0] op;
      rst = 1'b1; ena = 1'b0; opcode = 3'd0; zero = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset_state", outs(), 9'b0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 4000; i++) begin
         ena  = ($urandom_range(0, 9) < 8);
         zero = $urandom_range(0, 1);
         op   = 3'($urandom_range(0, 7));
         if (op == 3'd0 && $urandom_range(0, 5) != 0) op = 3'd2;
         opcode = op;
         @(posedge clk);
         model_edge();
         #1;
         check_eq("cycle", outs(), expected());
         if (!(rd && wr)) passed = passed; else check_eq("rd_wr_excl", {rd, wr}, 9'b0);
         if ((m_mode == 2 && halted_cycles >= 20) || $urandom_range(0, 199) == 0)
            async_reset();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
